message_receive: RTL and testbench

MESSAGE_RECEIVE -- requirements
Module: message_receive

---
 rtl/message_pkg.sv | 22 ++
 rtl/message_receive_bit_sync.sv | 29 ++
 rtl/message_receive.sv | 151 +++++++++++++++
 tb/tb_message_receive.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/message_pkg.sv
`default_nettype none
// ============================================================================
// message_pkg : shared types and constants for the serial message receiver.
// Revision    : 1.0
// ============================================================================
package message_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int   MSG_W_DEF      = 5;
  localparam int   BIT_CYCLES_DEF = 16;
  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;

endpackage
`default_nettype wire

// File: rtl/message_receive_bit_sync.sv
`default_nettype none
// ============================================================================
// bit_sync : two-flop synchronizer; both flops reset to 1 (line idle level).
// Revision : 1.0
// ============================================================================
module bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/message_receive.sv
`default_nettype none
// ============================================================================
// message_receive : serial frame receiver (start, MSG_W data LSB-first, stop).
// Optional even-parity bit and parity_err when PARITY_CHECK_EN is defined.
// Revision        : 1.0
// ============================================================================
module message_receive
  import message_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_DEF,
  parameter int MSG_W      = MSG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SerIn,
  output logic [MSG_W-1:0] MSG_out,
  output logic             valid,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam int IDX_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_W - 1);

  rx_state_t        r_state;
  rx_state_t        w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [MSG_W-1:0] r_shift;
  logic [MSG_W:0]   w_shift_in;
  logic             w_sync;
  logic             r_sync_d;
  logic             w_fall;
  logic             w_tick;

  bit_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (SerIn),
    .o_q   (w_sync)
  );

  assign w_fall     = r_sync_d & ~w_sync;
  assign w_shift_in = {w_sync, r_shift};
  assign busy       = (r_state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // START samples at mid start bit; later bits then sample one full period apart.
  always_comb begin
    w_next = r_state;
    w_tick = 1'b0;
    case (r_state)
      IDLE: if (w_fall) w_next = START;
      START: begin
        w_tick = (r_cnt == HALF_CNT);
        if (w_tick) w_next = (w_sync == START_BIT) ? DATA : IDLE;
      end
      DATA: begin
        w_tick = (r_cnt == LAST_CNT);
        if (w_tick && (r_idx == LAST_IDX)) begin
`ifdef PARITY_CHECK_EN
          w_next = PARITY;
`else
          w_next = STOP;
`endif
        end
      end
      PARITY: begin
        w_tick = (r_cnt == LAST_CNT);
        if (w_tick) w_next = STOP;
      end
      STOP: begin
        w_tick = (r_cnt == LAST_CNT);
        if (w_tick) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef PARITY_CHECK_EN
  logic r_par_err;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_sync_d  <= 1'b1;
      MSG_out   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_par_err  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      r_sync_d  <= w_sync;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
      if ((r_state == IDLE) || w_tick) r_cnt <= '0;
      else                             r_cnt <= r_cnt + 1'b1;

      case (r_state)
        IDLE: begin
          r_idx <= '0;
`ifdef PARITY_CHECK_EN
          r_par_err <= 1'b0;
`endif
        end
        DATA: if (w_tick) begin
          r_shift <= w_shift_in[MSG_W:1];
          r_idx   <= r_idx + 1'b1;
        end
`ifdef PARITY_CHECK_EN
        PARITY: if (w_tick) r_par_err <= (^r_shift) ^ w_sync;
`endif
        STOP: if (w_tick) begin
          if (w_sync != STOP_BIT) begin
            frame_err <= 1'b1;
`ifdef PARITY_CHECK_EN
          end else if (r_par_err) begin
            parity_err <= 1'b1;
`endif
          end else begin
            MSG_out <= r_shift;
            valid   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef PARITY_CHECK_EN
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_message_receive.sv
`default_nettype none
// Directed self-checking bench for message_receive (BIT_CYCLES=16, MSG_W=5);
// frames include the parity bit when PARITY_CHECK_EN is defined.
module tb_message_receive;

  localparam int BITC = 16;
`ifdef PARITY_CHECK_EN
  localparam int FRAME_BITS = 8;
`else
  localparam int FRAME_BITS = 7;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       SerIn = 1'b1;
  logic [4:0] MSG_out;
  logic       valid, busy, frame_err, parity_err;

  int checks = 0;
  int failures = 0;

  int         n_valid = 0, n_ferr = 0, n_perr = 0, cycle = 0;
  logic [4:0] v_data [4];
  int         v_cyc  [4];

  message_receive #(.BIT_CYCLES(BITC), .MSG_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .SerIn      (SerIn),
    .MSG_out    (MSG_out),
    .valid      (valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cycle = cycle + 1;
    if (valid) begin
      if (n_valid < 4) begin
        v_data[n_valid] = MSG_out;
        v_cyc[n_valid]  = cycle;
      end
      n_valid = n_valid + 1;
    end
    if (frame_err)  n_ferr = n_ferr + 1;
    if (parity_err) n_perr = n_perr + 1;
  end

  task automatic clear_counts();
    n_valid = 0; n_ferr = 0; n_perr = 0;
  endtask

  task automatic send_bit(input logic b);
    SerIn = b;
    repeat (BITC) @(posedge clk);
    #1;
  endtask

  // Caller aligns to posedge+1; consecutive calls leave no idle gap.
  task automatic send_frame(input logic [4:0] d, input logic stop_b, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(d[i]);
`ifdef PARITY_CHECK_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) begin end
`endif
    send_bit(stop_b);
    SerIn = 1'b1;
  endtask

  task automatic idle(input int n);
    SerIn = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (MSG_out !== 5'b0) begin failures++; $display("FAIL reset_msg got=%b exp=00000", MSG_out); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
    reset = 1'b1;
    @(posedge clk); #1;
    idle(5);
  endtask

  task automatic test_good_frame();
    clear_counts();
    send_frame(5'b11011, 1'b1, 1'b0);
    idle(20);
    @(negedge clk);
    checks++; if (n_valid !== 1) begin failures++; $display("FAIL good_valid_count got=%0d exp=1", n_valid); end
    checks++; if (MSG_out !== 5'b11011) begin failures++; $display("FAIL good_msg got=%b exp=11011", MSG_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL good_busy got=%b exp=0", busy); end
    checks++; if (n_ferr + n_perr !== 0) begin failures++; $display("FAIL good_err_count got=%0d exp=0", n_ferr + n_perr); end
  endtask

  task automatic test_glitch();
    clear_counts();
    @(posedge clk); #1;
    SerIn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    SerIn = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_start_busy got=%b exp=1", busy); end
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%b exp=0", busy); end
    idle(20);
    checks++; if (n_valid + n_ferr + n_perr !== 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", n_valid + n_ferr + n_perr); end
    checks++; if (MSG_out !== 5'b11011) begin failures++; $display("FAIL glitch_msg got=%b exp=11011", MSG_out); end
  endtask

  task automatic test_frame_err();
    clear_counts();
    send_frame(5'b10101, 1'b0, 1'b0);
    idle(20);
    checks++; if (n_ferr !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", n_ferr); end
    checks++; if (n_valid !== 0) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", n_valid); end
    checks++; if (MSG_out !== 5'b11011) begin failures++; $display("FAIL ferr_msg got=%b exp=11011", MSG_out); end
  endtask

  task automatic test_parity();
    clear_counts();
    send_frame(5'b10101, 1'b1, 1'b1);
    idle(20);
`ifdef PARITY_CHECK_EN
    checks++; if (n_perr !== 1) begin failures++; $display("FAIL perr_count got=%0d exp=1", n_perr); end
    checks++; if (n_valid !== 0) begin failures++; $display("FAIL perr_valid got=%0d exp=0", n_valid); end
    checks++; if (MSG_out !== 5'b11011) begin failures++; $display("FAIL perr_msg got=%b exp=11011", MSG_out); end
`else
    checks++; if (n_perr !== 0) begin failures++; $display("FAIL noparity_perr got=%0d exp=0", n_perr); end
    checks++; if (n_valid !== 1) begin failures++; $display("FAIL noparity_valid got=%0d exp=1", n_valid); end
    checks++; if (MSG_out !== 5'b10101) begin failures++; $display("FAIL noparity_msg got=%b exp=10101", MSG_out); end
`endif
  endtask

  task automatic test_reset_midframe();
    clear_counts();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    SerIn = 1'b1;
    repeat (BITC / 2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (MSG_out !== 5'b0) begin failures++; $display("FAIL midrst_msg got=%b exp=00000", MSG_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if ({valid, frame_err, parity_err} !== 3'b000) begin failures++; $display("FAIL midrst_pulses got=%b exp=000", {valid, frame_err, parity_err}); end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(40);
    checks++; if (n_valid + n_ferr + n_perr !== 0) begin failures++; $display("FAIL midrst_abort got=%0d exp=0", n_valid + n_ferr + n_perr); end
    send_frame(5'b00111, 1'b1, 1'b0);
    idle(20);
    checks++; if (n_valid !== 1) begin failures++; $display("FAIL midrst_valid got=%0d exp=1", n_valid); end
    checks++; if (MSG_out !== 5'b00111) begin failures++; $display("FAIL midrst_msg2 got=%b exp=00111", MSG_out); end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_frame(5'b11011, 1'b1, 1'b0);
    send_frame(5'b00001, 1'b1, 1'b0);
    idle(20);
    checks++; if (n_valid !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", n_valid); end
    if (n_valid >= 2) begin
      checks++; if (v_data[0] !== 5'b11011) begin failures++; $display("FAIL b2b_first got=%b exp=11011", v_data[0]); end
      checks++; if (v_data[1] !== 5'b00001) begin failures++; $display("FAIL b2b_second got=%b exp=00001", v_data[1]); end
      checks++; if (v_cyc[1] - v_cyc[0] !== FRAME_BITS * BITC) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", v_cyc[1] - v_cyc[0], FRAME_BITS * BITC); end
    end
    checks++; if (n_ferr + n_perr !== 0) begin failures++; $display("FAIL b2b_errs got=%0d exp=0", n_ferr + n_perr); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err();
    test_parity();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
